// File: rtl/div32_seq.sv
// Sequential restoring divider for sign-magnitude operands: one quotient bit per clock,
// with a start/done handshake. The trial remainder is formed by the sub32 subtractor.

module sub32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff
);
  localparam int M = WIDTH - 1;

  logic         b_neg_sign;
  logic         sgn;
  logic [M-1:0] am;
  logic [M-1:0] bm;
  logic [M-1:0] mag;

  always_comb begin
    am         = a[M-1:0];
    bm         = b[M-1:0];
    b_neg_sign = ~b[M];
    mag        = '0;
    sgn        = 1'b0;
    // a - b is evaluated as a + (-b) in sign-magnitude form
    if (a[M] == b_neg_sign) begin
      mag = am + bm;
      sgn = a[M];
    end else if (am >= bm) begin
      mag = am - bm;
      sgn = a[M];
    end else begin
      mag = bm - am;
      sgn = b_neg_sign;
    end
    diff = {(mag != '0) & sgn, mag};
  end
endmodule

module div32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int M  = WIDTH - 1;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(M);

  typedef enum logic [1:0] {IDLE, RUN, DZERO, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [M-1:0]  pr;
  logic [M-1:0]  dd;
  logic [M-1:0]  dv;
  logic          q_sign;
  logic          r_sign;
  logic [M-1:0]  pr_shift;
  logic [M:0]    trial;

  // pr < dv and only dividend prefixes of at most M-1 bits reach pr before the
  // last shift, so pr_shift never needs an extra bit
  assign pr_shift = {pr[M-2:0], dd[M-1]};

  sub32 #(.WIDTH(WIDTH)) u_trial (
    .a    ({1'b0, pr_shift}),
    .b    ({1'b0, dv}),
    .diff (trial)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pr          <= '0;
      dd          <= '0;
      dv          <= '0;
      q_sign      <= 1'b0;
      r_sign      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            dd     <= dividend[M-1:0];
            dv     <= divisor[M-1:0];
            pr     <= '0;
            cnt    <= '0;
            q_sign <= dividend[M] ^ divisor[M];
            r_sign <= dividend[M];
            if (divisor[M-1:0] == '0) begin
              state <= DZERO;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (cnt == LAST) begin
            // dd now holds the quotient magnitude, pr the remainder magnitude
            quotient    <= {(dd != '0) & q_sign, dd};
            remainder   <= {(pr != '0) & r_sign, pr};
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
            if (!trial[M]) begin
              pr <= trial[M-1:0];
              dd <= {dd[M-2:0], 1'b1};
            end else begin
              pr <= pr_shift;
              dd <= {dd[M-2:0], 1'b0};
            end
          end
        end
        DZERO: begin
          quotient    <= {q_sign, {M{1'b1}}};
          remainder   <= {(dd != '0) & r_sign, dd};
          div_by_zero <= 1'b1;
          done        <= 1'b1;
          state       <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div32_seq.sv
// Scoreboard bench for div32_seq: expected results are queued at start and
// compared against quotient/remainder/flag, latency and busy length at done.

module tb_div32_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  div32_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          k;
    int          lat;
    int          busy_len;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int k);
    exp_t        e;
    logic [30:0] am, bm, qm, rm;
    logic        qs;
    am = a[30:0];
    bm = b[30:0];
    qs = a[31] ^ b[31];
    e.k = k;
    if (bm == 0) begin
      e.q = {qs, 31'h7FFF_FFFF};
      e.r = (am == 0) ? 32'h0 : a;
      e.dz = 1'b1;
      e.lat = 1;
      e.busy_len = 0;
    end else begin
      qm = am / bm;
      rm = am % bm;
      e.q = (qm == 0) ? 32'h0 : {qs, qm};
      e.r = (rm == 0) ? 32'h0 : {a[31], rm};
      e.dz = 1'b0;
      e.lat = 32;
      e.busy_len = 32;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'(done), 32'h0);
        end else begin
          e = sb.pop_front();
          check("quotient", quotient, e.q);
          check("remainder", remainder, e.r);
          check("div_by_zero", 32'(div_by_zero), 32'(e.dz));
          check("latency", 32'(cyc - e.k), 32'(e.lat));
          check("busy_cycles", 32'(busy_cnt), 32'(e.busy_len));
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic pulse(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    pulse(a, b);
    sb.push_back(model(a, b, cyc));
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    @(negedge clk);
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'h0);
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b);
    issue(a, b);
    drain();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
    check({tag, "_quot"}, quotient, 32'h0);
    check({tag, "_rem"}, remainder, 32'h0);
    check({tag, "_dz"}, 32'(div_by_zero), 32'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    run_op(32'h0000_0064, 32'h0000_0007);
    run_op(32'h8000_0064, 32'h0000_0007);
    run_op(32'h8000_0064, 32'h8000_0007);
    run_op(32'h0000_0003, 32'h8000_0005);
    run_op(32'h0000_0009, 32'h8000_0000);
    run_op(32'h0000_0008, 32'h0000_0002);
    run_op(32'h8000_0000, 32'h0000_0000);

    // starts during RUN must be ignored
    issue(32'h1234_5678, 32'h0000_0123);
    repeat (4) @(posedge clk);
    pulse(32'h0000_FFFF, 32'h0000_0003);
    repeat (14) @(posedge clk);
    pulse(32'h0000_0010, 32'h0000_0000);
    drain();

    // back-to-back: second start held in the DONE cycle
    issue(32'h0001_0000, 32'h0000_0100);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (done) break;
    end
    if (!done) check("b2b_done_timeout", 32'(done), 32'h1);
    issue(32'h8765_4321, 32'h0000_1234);
    drain();

    // reset mid-RUN aborts the operation
    issue(32'h0000_03E8, 32'h0000_0003);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_zero_outputs("abort");
    sb.delete();
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (40) @(posedge clk);

    run_op(32'h7FFF_FFFF, 32'h0000_0001);
    run_op(32'h7FFF_FFFF, 32'h7FFF_FFFE);
    run_op(32'h0000_0005, 32'h0000_0005);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = {1'($urandom_range(0, 1)), 31'($urandom_range(1, 65535))};
      run_op(a, b);
    end

    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
